// File: rtl/b10_vote_arbiter_pkg.sv
// ============================================================================
// Module      : b10_pkg
// Description : Shared types, widths and the vote parity helper for the
//               b10 voting-terminal arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package b10_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        COMMIT    = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    localparam int VOTE_W  = 4;
    localparam int SRC_W   = 3;
    localparam int TIMER_W = 8;

    // Bit 3 is the parity bit over the three data bits.
    function automatic logic vote_parity_ok(input logic [3:0] vote);
        return vote[3] == (vote[0] ^ vote[1] ^ vote[2]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/b10_vote_arbiter_if.sv
// ============================================================================
// Module      : b10_vote_arbiter_if
// Description : Terminal-array and tally-side signal bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface b10_vote_arbiter_if
    import b10_pkg::*;
#(
    parameter int NUM_ST = 4,
    parameter int CNT_W  = 8
);
    logic                       enable;
    logic [NUM_ST-1:0]          st_req;
    logic [NUM_ST-1:0]          st_rts;
    logic [VOTE_W*NUM_ST-1:0]   st_vote;
    logic [NUM_ST-1:0]          st_ctr;
    logic                       tally_valid;
    logic [VOTE_W-1:0]          tally_code;
    logic [SRC_W-1:0]           tally_src;
    logic                       tally_ok;
    logic [CNT_W-1:0]           accept_cnt;
    logic [CNT_W-1:0]           reject_cnt;
    logic                       busy;
    logic                       tmo_err;

    modport master (
        output enable, st_req, st_rts, st_vote,
        input  st_ctr, tally_valid, tally_code, tally_src, tally_ok,
               accept_cnt, reject_cnt, busy, tmo_err
    );

    modport slave (
        input  enable, st_req, st_rts, st_vote,
        output st_ctr, tally_valid, tally_code, tally_src, tally_ok,
               accept_cnt, reject_cnt, busy, tmo_err
    );
endinterface

`default_nettype wire

// File: rtl/b10_vote_arbiter_rr_pick.sv
// ============================================================================
// Module      : b10_rr_pick
// Description : Combinational round-robin picker: first requester at or after
//               the pointer, wrapping, as one-hot grant plus index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module b10_rr_pick
    import b10_pkg::*;
#(
    parameter int NUM_ST = 4
) (
    input  wire logic [NUM_ST-1:0] i_req,
    input  wire logic [SRC_W-1:0]  i_ptr,
    output logic      [NUM_ST-1:0] o_grant,
    output logic      [SRC_W-1:0]  o_idx,
    output logic                   o_any
);

    int w_best;
    int w_off;

    // Smallest circular distance from the pointer wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_best = NUM_ST;
        w_off  = 0;
        for (int j = 0; j < NUM_ST; j++) begin
            w_off = (j + NUM_ST - int'(i_ptr)) % NUM_ST;
            if (i_req[j] && (w_off < w_best)) begin
                w_best = w_off;
                o_idx  = SRC_W'(j);
                o_any  = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_ST; j++) begin
            o_grant[j] = o_any && (o_idx == SRC_W'(j));
        end
    end

endmodule

`default_nettype wire

// File: rtl/b10_vote_arbiter.sv
// ============================================================================
// Module      : b10_vote_arbiter
// Description : Round-robin arbiter and parity-checking vote collector for
//               NUM_ST terminals sharing one tally channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module b10_vote_arbiter
    import b10_pkg::*;
#(
    parameter int NUM_ST  = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 15
) (
    input  wire logic          clock,
    input  wire logic          reset,
    b10_vote_arbiter_if.slave  bus
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [NUM_ST-1:0]   r_sel_oh;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [TIMER_W-1:0]  r_timer;
    logic [VOTE_W-1:0]   r_tally_code;
    logic [SRC_W-1:0]    r_tally_src;
    logic                r_tally_ok;
    logic [CNT_W-1:0]    r_accept_cnt;
    logic [CNT_W-1:0]    r_reject_cnt;
    logic                r_tmo_err;

    logic [NUM_ST-1:0]   w_pick_oh;
    logic [SRC_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_start;
    logic                w_sel_rts;
    logic                w_sel_req;
    logic                w_timeout;
    logic [VOTE_W-1:0]   w_sel_vote;
    logic [NUM_ST-1:0]   w_ctr;
    logic                w_valid;
    logic                w_busy;

    b10_rr_pick #(
        .NUM_ST (NUM_ST)
    ) u_pick (
        .i_req   (bus.st_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_start   = bus.enable && w_pick_any;
    assign w_sel_rts = |(bus.st_rts & r_sel_oh);
    assign w_sel_req = |(bus.st_req & r_sel_oh);
    assign w_timeout = (r_timer == TIMER_W'(TMO_CYC - 1));

    always_comb begin
        w_sel_vote = '0;
        for (int j = 0; j < NUM_ST; j++) begin
            if (r_sel_oh[j]) begin
                w_sel_vote = bus.st_vote[VOTE_W*j +: VOTE_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rts is tested before the timeout so a same-edge rts always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_ctr       = '0;
        w_valid     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_start) begin
                    w_state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                w_ctr = r_sel_oh;
                if (w_sel_rts) begin
                    w_state_nxt = COMMIT;
                end else if (w_timeout) begin
                    w_state_nxt = RELEASE;
                end
            end
            COMMIT: begin
                w_valid     = 1'b1;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!w_sel_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel_oh     <= '0;
            r_rr_ptr     <= '0;
            r_timer      <= '0;
            r_tally_code <= '0;
            r_tally_src  <= '0;
            r_tally_ok   <= 1'b0;
            r_accept_cnt <= '0;
            r_reject_cnt <= '0;
            r_tmo_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sel_oh    <= w_pick_oh;
                        r_tally_src <= w_pick_idx;
                    end
                end
                WAIT_DATA: begin
                    if (w_sel_rts) begin
                        r_tally_code <= w_sel_vote;
                        r_tally_ok   <= vote_parity_ok(w_sel_vote);
                    end else if (w_timeout) begin
                        r_tmo_err <= 1'b1;
                        if (r_reject_cnt != {CNT_W{1'b1}}) begin
                            r_reject_cnt <= r_reject_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                COMMIT: begin
                    if (r_tally_ok) begin
                        if (r_accept_cnt != {CNT_W{1'b1}}) begin
                            r_accept_cnt <= r_accept_cnt + 1'b1;
                        end
                    end else if (r_reject_cnt != {CNT_W{1'b1}}) begin
                        r_reject_cnt <= r_reject_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!w_sel_req) begin
                        r_timer  <= '0;
                        r_rr_ptr <= (r_tally_src == SRC_W'(NUM_ST - 1)) ? '0
                                                                        : r_tally_src + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.st_ctr      = w_ctr;
    assign bus.tally_valid = w_valid;
    assign bus.tally_code  = r_tally_code;
    assign bus.tally_src   = r_tally_src;
    assign bus.tally_ok    = r_tally_ok;
    assign bus.accept_cnt  = r_accept_cnt;
    assign bus.reject_cnt  = r_reject_cnt;
    assign bus.busy        = w_busy;
    assign bus.tmo_err     = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_b10_vote_arbiter.sv
// ============================================================================
// Module      : tb_b10_vote_arbiter
// Description : Randomized transaction bench for b10_vote_arbiter with a
//               transaction-level reference model; a CNT_W=2 twin shares stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_b10_vote_arbiter;
    import b10_pkg::*;

    localparam int NUM_ST = 4;
    localparam int TMO    = 15;

    logic clock = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    int m_ptr = 0;
    int m_acc = 0;
    int m_rej = 0;
    int m_tmo = 0;

    b10_vote_arbiter_if #(.NUM_ST(NUM_ST), .CNT_W(8)) bus ();
    b10_vote_arbiter_if #(.NUM_ST(NUM_ST), .CNT_W(2)) bus2 ();

    assign bus2.enable  = bus.enable;
    assign bus2.st_req  = bus.st_req;
    assign bus2.st_rts  = bus.st_rts;
    assign bus2.st_vote = bus.st_vote;

    b10_vote_arbiter #(.NUM_ST(NUM_ST), .CNT_W(8), .TMO_CYC(TMO)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    b10_vote_arbiter #(.NUM_ST(NUM_ST), .CNT_W(2), .TMO_CYC(TMO)) u_dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < NUM_ST; k++) begin
            if (req[(ptr + k) % NUM_ST]) return (ptr + k) % NUM_ST;
        end
        return -1;
    endfunction

    task automatic check_counters();
        chk("accept_cnt",  32'(bus.accept_cnt),  sat(m_acc, 255));
        chk("reject_cnt",  32'(bus.reject_cnt),  sat(m_rej, 255));
        chk("accept_sat2", 32'(bus2.accept_cnt), sat(m_acc, 3));
        chk("reject_sat2", 32'(bus2.reject_cnt), sat(m_rej, 3));
        chk("tmo_err",     32'(bus.tmo_err),     m_tmo);
    endtask

    // One complete transaction, entered and left at a negedge with the DUT idle.
    task automatic txn(input logic [3:0] req, input logic [15:0] votes,
                       input int d, input int h, input int blk);
        int         sel;
        logic [3:0] oh;
        logic [3:0] v;
        logic       ok;
        bus.st_rts  = '0;
        bus.st_vote = votes;
        bus.st_req  = req;
        if (blk > 0) begin
            bus.enable = 1'b0;
            repeat (blk) begin
                @(negedge clock);
                chk("blocked_ctr",  32'(bus.st_ctr), 0);
                chk("blocked_busy", 32'(bus.busy),   0);
            end
        end
        bus.enable = 1'b1;
        sel = pick(req, m_ptr);
        oh  = 4'b0001 << sel;
        v   = votes[4*sel +: 4];
        @(negedge clock);
        chk("grant", 32'(bus.st_ctr), 32'(oh));
        chk("busy",  32'(bus.busy),   1);
        if (d < TMO) begin
            repeat (d) begin
                bus.st_rts = 4'($urandom) & ~oh;
                bus.enable = 1'($urandom);
                if ($urandom_range(0, 3) == 0) bus.st_req = bus.st_req & ~oh;
                @(negedge clock);
                chk("grant_hold", 32'(bus.st_ctr), 32'(oh));
            end
            bus.st_rts = oh | (4'($urandom) & ~oh);
            @(negedge clock);
            bus.st_rts = '0;
            ok = ((^v) == 1'b0);
            chk("tally_valid", 32'(bus.tally_valid), 1);
            chk("tally_code",  32'(bus.tally_code),  32'(v));
            chk("tally_src",   32'(bus.tally_src),   sel);
            chk("tally_ok",    32'(bus.tally_ok),    32'(ok));
            chk("ctr_dropped", 32'(bus.st_ctr),      0);
            if (ok) m_acc++;
            else    m_rej++;
            @(negedge clock);
            chk("valid_pulse", 32'(bus.tally_valid), 0);
        end else begin
            repeat (TMO - 1) begin
                bus.st_rts = 4'($urandom) & ~oh;
                @(negedge clock);
                chk("tmo_hold",  32'(bus.st_ctr),      32'(oh));
                chk("tmo_novld", 32'(bus.tally_valid), 0);
            end
            @(negedge clock);
            bus.st_rts = '0;
            chk("tmo_drop",  32'(bus.st_ctr),      0);
            chk("tmo_valid", 32'(bus.tally_valid), 0);
            m_rej++;
            m_tmo = 1;
        end
        check_counters();
        repeat (h) begin
            bus.st_req = bus.st_req | oh;
            @(negedge clock);
            chk("release_busy", 32'(bus.busy),   1);
            chk("release_ctr",  32'(bus.st_ctr), 0);
        end
        bus.st_req = bus.st_req & ~oh;
        @(negedge clock);
        chk("idle_busy", 32'(bus.busy),   0);
        chk("idle_ctr",  32'(bus.st_ctr), 0);
        m_ptr = (sel + 1) % NUM_ST;
    endtask

    // Async reset asserted while a terminal holds the grant.
    task automatic reset_mid();
        bus.st_req  = 4'($urandom_range(1, 15));
        bus.st_rts  = '0;
        bus.enable  = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        m_ptr = 0; m_acc = 0; m_rej = 0; m_tmo = 0;
        chk("rst_ctr",   32'(bus.st_ctr),      0);
        chk("rst_busy",  32'(bus.busy),        0);
        chk("rst_valid", 32'(bus.tally_valid), 0);
        check_counters();
        bus.st_req = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int d;
        int r;
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.st_req  = '0;
        bus.st_rts  = '0;
        bus.st_vote = '0;
        repeat (3) @(negedge clock);
        chk("reset_ctr",   32'(bus.st_ctr),      0);
        chk("reset_busy",  32'(bus.busy),        0);
        chk("reset_valid", 32'(bus.tally_valid), 0);
        chk("reset_code",  32'(bus.tally_code),  0);
        chk("reset_src",   32'(bus.tally_src),   0);
        chk("reset_ok",    32'(bus.tally_ok),    0);
        check_counters();
        reset = 1'b1;
        @(negedge clock);

        txn(4'b0010, 16'h0060, 2, 1, 0);
        txn(4'b0001, 16'($urandom), 1, 0, 3);
        reset_mid();
        repeat (5) txn(4'b1111, 16'($urandom), 2, 1, 0);
        txn(4'b0100, 16'($urandom), 20, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      d = $urandom_range(0, 4);
            else if (r < 8) d = TMO - 1;
            else            d = $urandom_range(TMO, TMO + 5);
            txn(4'($urandom_range(1, 15)), 16'($urandom), d,
                $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
        end

        reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
